// File: rtl/press_counter_pkg.sv
// Shared types and constants for the debounced press counter.
// Used by key_debounce, press_counter and press_counter_if.
package press_counter_pkg;

    typedef enum logic [1:0] {IDLE, ARM, DOWN, REL} db_state_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/press_counter_if.sv
// Board-side signal bundle for the press counter: raw key, switches and digit outputs.
// master drives the key/switches, slave is the counter itself.
interface press_counter_if;
    import press_counter_pkg::*;

    logic                          KEY_N;
    logic                          DIR;
    logic                          CLR;
    logic [DIGIT_W*NUM_DIGITS-1:0] DIGIT;
    logic                          PRESS;

    modport master (output KEY_N, output DIR, output CLR, input DIGIT, input PRESS);
    modport slave  (input KEY_N, input DIR, input CLR, output DIGIT, output PRESS);

endinterface

// File: rtl/key_debounce.sv
// Synchronises an active-low key and filters bounce with a four-state FSM.
// press pulses for one cycle when a press is accepted; level is high while held.
module key_debounce
    import press_counter_pkg::*;
#(
    parameter int DB_CYCLES = 50000,
    parameter int CW        = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press,
    output logic level
);

    logic [1:0]    key_sync_reg;
    db_state_t     state_reg;
    logic [CW-1:0] cnt_reg;
    logic          press_reg;

    logic          k;
    logic [CW-1:0] cnt_inc;
    logic          cnt_hit;

    assign k       = key_sync_reg[1];
    assign cnt_inc = cnt_reg + 1'b1;
    assign cnt_hit = (cnt_inc == CW'(DB_CYCLES));

    // Synchroniser resets to "released" so a key held through reset is re-debounced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_sync_reg <= 2'b11;
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            press_reg    <= 1'b0;
        end else begin
            key_sync_reg <= {key_sync_reg[0], key_n};
            press_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!k) begin
                        state_reg <= ARM;
                        cnt_reg   <= CW'(1);
                    end
                end
                ARM: begin
                    if (k) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_inc;
                        if (cnt_hit) begin
                            state_reg <= DOWN;
                            press_reg <= 1'b1;
                        end
                    end
                end
                DOWN: begin
                    if (k) begin
                        state_reg <= REL;
                        cnt_reg   <= CW'(1);
                    end
                end
                REL: begin
                    if (!k) begin
                        state_reg <= DOWN;
                    end else begin
                        cnt_reg <= cnt_inc;
                        if (cnt_hit) state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign press = press_reg;
    assign level = (state_reg == DOWN) || (state_reg == REL);

endmodule

// File: rtl/press_counter.sv
// Debounced pushbutton up/down counter feeding four hex-digit decoders.
// Define PRESS_COUNTER_BCD_EN for 4-digit BCD counting; default is 16-bit hex.
module press_counter
    import press_counter_pkg::*;
#(
    parameter int DB_CYCLES = 50000,
    parameter int CW        = 20
) (
    input  logic           CLOCK_50,
    input  logic           RST_N,
    press_counter_if.slave bus
);

    localparam int W = DIGIT_W * NUM_DIGITS;

    logic [1:0]   dir_sync_reg;
    logic [1:0]   clr_sync_reg;
    logic [W-1:0] digit_reg;
    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         press;
    logic         level;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CW        (CW)
    ) u_db (
        .clk   (CLOCK_50),
        .rst_n (RST_N),
        .key_n (bus.KEY_N),
        .press (press),
        .level (level)
    );

`ifdef PRESS_COUNTER_BCD_EN
    // Ripple chains: a digit moves only when every lower digit wraps.
    logic [NUM_DIGITS-1:0] carry;
    logic [NUM_DIGITS-1:0] borrow;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_bcd
        logic [DIGIT_W-1:0] d;
        assign d = digit_reg[gi*DIGIT_W +: DIGIT_W];
        assign inc_val[gi*DIGIT_W +: DIGIT_W] =
            !carry[gi] ? d : ((d == BCD_MAX) ? '0 : d + 1'b1);
        assign dec_val[gi*DIGIT_W +: DIGIT_W] =
            !borrow[gi] ? d : ((d == '0) ? BCD_MAX : d - 1'b1);
        if (gi < NUM_DIGITS - 1) begin : g_chain
            assign carry[gi+1]  = carry[gi] && (d == BCD_MAX);
            assign borrow[gi+1] = borrow[gi] && (d == '0);
        end
    end
`else
    assign inc_val = digit_reg + 1'b1;
    assign dec_val = digit_reg - 1'b1;
`endif

    // The press pulse only fires on entry to the held state, so level qualifies it.
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            dir_sync_reg <= '0;
            clr_sync_reg <= '0;
            digit_reg    <= '0;
        end else begin
            dir_sync_reg <= {dir_sync_reg[0], bus.DIR};
            clr_sync_reg <= {clr_sync_reg[0], bus.CLR};
            if (clr_sync_reg[1])
                digit_reg <= '0;
            else if (press && level)
                digit_reg <= dir_sync_reg[1] ? inc_val : dec_val;
        end
    end

    assign bus.DIGIT = digit_reg;
    assign bus.PRESS = press;

endmodule

// File: tb/tb_press_counter.sv
// Directed bench for press_counter with DB_CYCLES=4; expectations follow the
// build mode selected by PRESS_COUNTER_BCD_EN.
module tb_press_counter;

    localparam int DB = 4;

`ifdef PRESS_COUNTER_BCD_EN
    localparam logic [15:0] EXP_15   = 16'h0015;
    localparam logic [15:0] EXP_16   = 16'h0016;
    localparam logic [15:0] EXP_NEG1 = 16'h9999;
    localparam logic [15:0] EXP_PRE  = 16'h0099;
    localparam int          N_PRE    = 99;
`else
    localparam logic [15:0] EXP_15   = 16'h000F;
    localparam logic [15:0] EXP_16   = 16'h0010;
    localparam logic [15:0] EXP_NEG1 = 16'hFFFF;
    localparam logic [15:0] EXP_PRE  = 16'h00FF;
    localparam int          N_PRE    = 255;
`endif

    logic CLOCK_50 = 1'b0;
    logic RST_N    = 1'b0;

    press_counter_if bus ();

    press_counter #(
        .DB_CYCLES (DB),
        .CW        (3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic        key_n;
        logic        exp_press;
        logic [15:0] exp_digit;
    } vec_t;

    vec_t tbl [32];
    int   tests  = 0;
    int   fails  = 0;
    int   npress = 0;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            if (bus.PRESS === 1'b1) npress++;
        end
    endtask

    task automatic do_press(input logic up);
        bus.DIR = up;
        run(3);
        bus.KEY_N = 1'b0;
        run(12);
        bus.KEY_N = 1'b1;
        run(12);
    endtask

    task automatic press_n(input logic up, input int n, input string name);
        npress = 0;
        for (int p = 0; p < n; p++) do_press(up);
        check(name, 16'(npress), 16'(n));
    endtask

    task automatic clear_count();
        bus.CLR = 1'b1;
        run(3);
        bus.CLR = 1'b0;
        run(3);
        check("clear", bus.DIGIT, 16'h0000);
    endtask

    initial begin
        // Clean press: edge driven before edge 1, PRESS in cycle 6, DIGIT=1 from cycle 7.
        for (int i = 0; i < 32; i++) begin
            tbl[i].key_n     = (i < 20) ? 1'b0 : 1'b1;
            tbl[i].exp_press = (i == 5) ? 1'b1 : 1'b0;
            tbl[i].exp_digit = (i >= 6) ? 16'h0001 : 16'h0000;
        end

        bus.KEY_N = 1'b1;
        bus.DIR   = 1'b1;
        bus.CLR   = 1'b0;
        RST_N     = 1'b0;
        run(3);
        check("reset digit", bus.DIGIT, 16'h0000);
        check("reset press", {15'd0, bus.PRESS}, 16'h0000);
        RST_N = 1'b1;
        run(3);

        for (int i = 0; i < 32; i++) begin
            bus.KEY_N = tbl[i].key_n;
            tick();
            check($sformatf("clean c%0d press", i + 1), {15'd0, bus.PRESS}, {15'd0, tbl[i].exp_press});
            check($sformatf("clean c%0d digit", i + 1), bus.DIGIT, tbl[i].exp_digit);
        end

        // Bounce: 2-cycle glitches for 12 cycles, then stable low driven at index 12.
        for (int i = 0; i < 30; i++) begin
            bus.KEY_N = (i < 12) ? logic'((i / 2) % 2) : 1'b0;
            tick();
            check($sformatf("bounce c%0d press", i + 1), {15'd0, bus.PRESS},
                  (i + 1 == 18) ? 16'h0001 : 16'h0000);
        end
        check("bounce digit", bus.DIGIT, 16'h0002);
        bus.KEY_N = 1'b1;
        run(12);

        // Wrap in both directions.
        clear_count();
        press_n(1'b1, 15, "preload 15 presses");
        check("preload 15", bus.DIGIT, EXP_15);
        do_press(1'b1);
        check("15 plus one", bus.DIGIT, EXP_16);
        clear_count();
        press_n(1'b0, 1, "down from zero presses");
        check("zero minus one", bus.DIGIT, EXP_NEG1);
        do_press(1'b1);
        check("max plus one", bus.DIGIT, 16'h0000);

        // Multi-digit carry and borrow.
        clear_count();
        press_n(1'b1, N_PRE, "preload carry presses");
        check("preload carry", bus.DIGIT, EXP_PRE);
        do_press(1'b1);
        check("carry up", bus.DIGIT, 16'h0100);
        do_press(1'b0);
        check("borrow down", bus.DIGIT, EXP_PRE);

        // CLR held through an accepted press discards it.
        bus.CLR = 1'b1;
        run(3);
        check("clr asserted", bus.DIGIT, 16'h0000);
        npress = 0;
        do_press(1'b1);
        check("clr press seen", 16'(npress), 16'd1);
        check("clr press discarded", bus.DIGIT, 16'h0000);
        bus.CLR = 1'b0;
        run(4);
        check("clr released", bus.DIGIT, 16'h0000);

        // One-cycle reset while in ARM aborts that press; held key re-debounces.
        do_press(1'b1);
        check("pre-reset count", bus.DIGIT, 16'h0001);
        bus.DIR   = 1'b1;
        bus.KEY_N = 1'b0;
        run(3);
        RST_N = 1'b0;
        tick();
        check("arm reset digit", bus.DIGIT, 16'h0000);
        check("arm reset press", {15'd0, bus.PRESS}, 16'h0000);
        RST_N = 1'b1;
        for (int c = 5; c <= 11; c++) begin
            tick();
            check($sformatf("post-reset c%0d press", c), {15'd0, bus.PRESS},
                  (c == 10) ? 16'h0001 : 16'h0000);
        end
        check("post-reset digit", bus.DIGIT, 16'h0001);
        bus.KEY_N = 1'b1;
        run(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
